rw_txn_scheduler: RTL



---
 rtl/rw_txn_scheduler_pkg.sv | 25 ++
 rtl/rw_txn_scheduler_queue.sv | 69 ++++++
 rtl/rw_txn_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rw_txn_scheduler_pkg.sv
// Shared types for the read/write transaction scheduler.
// - r_type    : which queue a request or completion belongs to (1 = write)
// - request   : host request (type, address, data)
// - mode_t    : turnaround mode of the scheduler
// - txn_tag_t : issue tag layout {type, slot} for the default 32-entry queue
package types_def;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TAG_SLOT_W = 5;

  typedef enum logic {R_READ = 1'b0, R_WRITE = 1'b1} r_type;

  typedef struct packed {
    r_type             req_type;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } request;

  typedef enum logic {READ = 1'b0, WDRAIN = 1'b1} mode_t;

  typedef struct packed {
    r_type                 tag_type;
    logic [TAG_SLOT_W-1:0] slot;
  } txn_tag_t;
endpackage

// File: rtl/rw_txn_scheduler_queue.sv
// txn_queue: in-order request storage with alloc/issue/retire pointers.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push, push_req    allocate an entry (caller guarantees room)
//   pop               advance the issue pointer (caller guarantees pending>0)
//   retire            advance the retire pointer (caller validated the tag)
//   head              entry at the issue pointer
//   pending           alloc - issue
//   issue_slot        slot of the issue pointer
//   retire_slot       slot of the retire pointer
//   has_issued        issue != retire (something is outstanding)
//   full              registered: occupancy == DEPTH after the last edge
module txn_queue
  import types_def::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  request                   push_req,
  input  logic                     pop,
  input  logic                     retire,
  output request                   head,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [$clog2(DEPTH)-1:0] issue_slot,
  output logic [$clog2(DEPTH)-1:0] retire_slot,
  output logic                     has_issued,
  output logic                     full
);
  localparam int SW = $clog2(DEPTH);
  localparam int PW = SW + 1;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW-1:0] alloc_ptr, issue_ptr, retire_ptr;
  logic [PW-1:0] alloc_nxt, retire_nxt, occ_nxt;
  request        mem [DEPTH];

  always_comb begin
    alloc_nxt  = alloc_ptr + PW'(push);
    retire_nxt = retire_ptr + PW'(retire);
    occ_nxt    = alloc_nxt - retire_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_ptr  <= '0;
      issue_ptr  <= '0;
      retire_ptr <= '0;
      full       <= 1'b0;
    end else begin
      alloc_ptr  <= alloc_nxt;
      issue_ptr  <= issue_ptr + PW'(pop);
      retire_ptr <= retire_nxt;
      full       <= (occ_nxt == PW'(DEPTH));
    end
  end

  // Storage needs no reset; entries are only read once allocated.
  always_ff @(posedge clk) begin
    if (push) mem[alloc_ptr[SW-1:0]] <= push_req;
  end

  assign head        = mem[issue_ptr[SW-1:0]];
  assign pending     = alloc_ptr - issue_ptr;
  assign issue_slot  = issue_ptr[SW-1:0];
  assign retire_slot = retire_ptr[SW-1:0];
  assign has_issued  = (issue_ptr != retire_ptr);
endmodule

// File: rtl/rw_txn_scheduler.sv
// rw_txn_scheduler: buffers host reads and writes in two in-order queues,
// issues one request per cycle to non-busy banks, and retires on tagged
// completions. A READ/WDRAIN mode FSM with write watermarks picks the queue.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   in_valid, in_request              host request
//   out_busy                          registered {write full, read full}
//   in_busy                           per-bank busy
//   out_valid, out_req, out_index     registered issue pulse, request, tag
//   done_valid, done_type, done_index completion
//   overflow_err                      request dropped (queue full)
//   done_err                          completion rejected
module rw_txn_scheduler
  import types_def::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int DEPTH     = 32,
  parameter int BANK_LSB  = 0,
  parameter int WR_HI     = 24,
  parameter int WR_LO     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  request                 in_request,
  output logic [1:0]             out_busy,
  input  logic [NUM_BANKS-1:0]   in_busy,
  output logic                   out_valid,
  output request                 out_req,
  output logic [$clog2(DEPTH):0] out_index,
  input  logic                   done_valid,
  input  r_type                  done_type,
  input  logic [$clog2(DEPTH):0] done_index,
  output logic                   overflow_err,
  output logic                   done_err
);
  localparam int SW = $clog2(DEPTH);
  localparam int PW = SW + 1;
  localparam int BW = $clog2(NUM_BANKS);

  logic [1:0]          push, pop, retire, full, has_issued;
  request              head [2];
  logic [1:0][PW-1:0]  pending;
  logic [1:0][SW-1:0]  issue_slot, retire_slot;
  mode_t               mode, mode_nxt;
  logic                sel, issue;
  request              head_sel;
  logic [BW-1:0]       bank;

  // Index 0 = read queue, 1 = write queue (matches the tag type bit).
  for (genvar q = 0; q < 2; q++) begin : g_q
    localparam r_type QT = (q == 1) ? R_WRITE : R_READ;

    assign retire[q] = done_valid && (done_type == QT) && has_issued[q] &&
                       (done_index == {QT, retire_slot[q]});
    // A full queue still accepts when the same edge retires an entry.
    assign push[q]   = in_valid && (in_request.req_type == QT) &&
                       (!full[q] || retire[q]);
    assign pop[q]    = issue && (sel == 1'(q));

    txn_queue #(.DEPTH(DEPTH)) u_q (
      .clk         (clk),
      .rst         (rst),
      .push        (push[q]),
      .push_req    (in_request),
      .pop         (pop[q]),
      .retire      (retire[q]),
      .head        (head[q]),
      .pending     (pending[q]),
      .issue_slot  (issue_slot[q]),
      .retire_slot (retire_slot[q]),
      .has_issued  (has_issued[q]),
      .full        (full[q])
    );
  end

  // Only the queue owned by the current mode may issue; its head blocks it.
  assign sel      = (mode == WDRAIN);
  assign head_sel = head[sel];
  assign bank     = head_sel.address[BANK_LSB +: BW];
  assign issue    = (pending[sel] != '0) && !in_busy[bank];

  always_ff @(posedge clk) begin
    if (!rst) mode <= READ;
    else      mode <= mode_nxt;
  end

  // Decided on this cycle's pending counts; the issue in the transition
  // cycle still follows the old mode.
  always_comb begin
    mode_nxt = mode;
    case (mode)
      READ:
        if (pending[1] >= PW'(WR_HI) || (pending[0] == '0 && pending[1] != '0))
          mode_nxt = WDRAIN;
      WDRAIN:
        if (pending[1] == '0 || (pending[1] <= PW'(WR_LO) && pending[0] != '0))
          mode_nxt = READ;
      default: mode_nxt = READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_req      <= '0;
      out_index    <= '0;
      overflow_err <= 1'b0;
      done_err     <= 1'b0;
    end else begin
      out_valid    <= issue;
      if (issue) begin
        out_req   <= head_sel;
        out_index <= {sel, issue_slot[sel]};
      end
      overflow_err <= in_valid && !(push[0] || push[1]);
      done_err     <= done_valid && !(retire[0] || retire[1]);
    end
  end

  assign out_busy = full;
endmodule
